// File: rtl/fir_pkg.sv
// Shared defaults, state encoding and arithmetic helpers for the FIR tap sequencer.
package fir_pkg;

    localparam int unsigned N_TAPS_DEF = 32;
    localparam int unsigned DW_DEF     = 16;
    localparam int unsigned CW_DEF     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_DRAIN = 2'd2
    } fir_state_e;

    // Accumulator wide enough that N_TAPS full-scale products cannot overflow.
    function automatic int unsigned acc_width(input int unsigned dw,
                                              input int unsigned cw,
                                              input int unsigned aw);
        return dw + cw + aw;
    endfunction

    // Clamp a signed value into the range of a w-bit signed number.
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] x,
                                                  input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/fir_tap_sequencer_mac.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
module fir_mac #(
    parameter int unsigned DW   = 16,
    parameter int unsigned CW   = 16,
    parameter int unsigned ACCW = 37
) (
    input  logic                   in_clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic signed [DW-1:0]   a_i,
    input  logic signed [CW-1:0]   b_i,
    output logic signed [ACCW-1:0] acc_next_c
);

    localparam int unsigned PW = DW + CW;

    logic signed [PW-1:0]   a_ext;
    logic signed [PW-1:0]   b_ext;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] acc_q;

    // Full-precision product added to the running sum.
    always_comb begin
        a_ext      = PW'(a_i);
        b_ext      = PW'(b_i);
        prod       = a_ext * b_ext;
        acc_next_c = acc_q + ACCW'(prod);
    end

    // Accumulator register; clear has priority over enable.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_next_c;
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR controller: sample history, tap sequencing, output scaling.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter  int unsigned N_TAPS = N_TAPS_DEF,
    parameter  int unsigned DW     = DW_DEF,
    parameter  int unsigned CW     = CW_DEF,
    localparam int unsigned AW     = $clog2(N_TAPS)
) (
    input  logic                 in_clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic signed [DW-1:0] din,
    output logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic signed [DW-1:0] dout,
    output logic                 dout_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int unsigned ACCW   = acc_width(DW, CW, AW);
    localparam logic [AW-1:0] LAST = AW'(N_TAPS - 1);
    localparam logic [AW:0]   N_EXT = (AW+1)'(N_TAPS);

    fir_state_e             state_q, state_d;
    logic [AW-1:0]          k_q, k_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic signed [DW-1:0]   buf_q [N_TAPS];
    logic signed [DW-1:0]   smp_q;
    logic signed [DW-1:0]   dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   buf_we;
    logic                   mac_clr;
    logic                   mac_en;
    logic [AW-1:0]          rd_idx;
    logic signed [ACCW-1:0] acc_next;
    logic signed [ACCW-1:0] acc_shift;
    logic signed [DW-1:0]   dout_sat;

    fir_mac #(
        .DW   (DW),
        .CW   (CW),
        .ACCW (ACCW)
    ) u_mac (
        .in_clk     (in_clk),
        .rst        (rst),
        .clr_i      (mac_clr),
        .en_i       (mac_en),
        .a_i        (smp_q),
        .b_i        (coef_data),
        .acc_next_c (acc_next)
    );

    // Read index (wr_ptr - k) mod N_TAPS; k=0 selects the newest sample.
    always_comb begin
        if (wr_ptr_q >= k_q) begin
            rd_idx = wr_ptr_q - k_q;
        end else begin
            rd_idx = AW'(N_EXT + {1'b0, wr_ptr_q} - {1'b0, k_q});
        end
    end

    // Rescale Q1.(CW-1) result by floor shift and clamp to the output range.
    always_comb begin
        acc_shift = acc_next >>> (CW - 1);
        dout_sat  = DW'(sat_to(64'(acc_shift), DW));
    end

    // Next-state and control decode.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        wr_ptr_d     = wr_ptr_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overrun_d    = overrun_q | (sample_tick & (state_q != ST_IDLE));
        buf_we       = 1'b0;
        mac_clr      = 1'b0;
        mac_en       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    buf_we  = 1'b1;
                    mac_clr = 1'b1;
                    k_d     = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                // First MAC cycle has no fetched operand pair yet.
                mac_en = (k_q != '0);
                if (k_q == LAST) begin
                    k_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                mac_en       = 1'b1;
                dout_d       = dout_sat;
                dout_valid_d = 1'b1;
                wr_ptr_d     = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            wr_ptr_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            wr_ptr_q     <= wr_ptr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    // Circular sample history.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_TAPS; i++) begin
                buf_q[i] <= '0;
            end
        end else if (buf_we) begin
            buf_q[wr_ptr_q] <= din;
        end
    end

    // Sample operand, aligned with the one-cycle ROM latency.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            smp_q <= '0;
        end else if (state_q == ST_MAC) begin
            smp_q <= buf_q[rd_idx];
        end
    end

    assign coef_addr  = k_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Randomized self-checking bench for fir_tap_sequencer against a convolution model.
module tb_fir_tap_sequencer;

    localparam int N  = 32;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int AW = $clog2(N);

    logic                 in_clk;
    logic                 rst;
    logic                 sample_tick;
    logic signed [DW-1:0] din;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic signed [DW-1:0] dout;
    logic                 dout_valid;
    logic                 busy;
    logic                 overrun;

    logic signed [CW-1:0] rom [N];
    longint               hist [N];
    int                   n_chk;
    int                   n_pass;
    longint               got_out;

    fir_tap_sequencer dut (
        .in_clk      (in_clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .din         (din),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // Synchronous coefficient ROM, one cycle read latency.
    always @(posedge in_clk) coef_data <= rom[coef_addr];

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: y = sat(floor(sum_k x[n-k]*c[k] / 2^(CW-1))).
    task automatic model_clear();
        for (int i = 0; i < N; i++) hist[i] = 0;
    endtask

    task automatic model_push(input longint x);
        for (int i = N - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = x;
    endtask

    function automatic longint model_out();
        longint s;
        longint hi;
        longint lo;
        s = 0;
        for (int k = 0; k < N; k++) s += hist[k] * longint'(rom[k]);
        s = s >>> (CW - 1);
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -(longint'(1) << (DW - 1));
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        return s;
    endfunction

    task automatic apply_reset();
        @(negedge in_clk);
        rst = 1'b0;
        sample_tick = 1'b0;
        repeat (2) @(negedge in_clk);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_addr", coef_addr, 0);
        rst = 1'b1;
        model_clear();
        @(negedge in_clk);
    endtask

    // One accepted tick at the current negedge; checks latency and value, then idles gap cycles.
    task automatic do_tick(input logic signed [DW-1:0] d, input int gap);
        longint exp;
        sample_tick = 1'b1;
        din = d;
        model_push(longint'(d));
        exp = model_out();
        for (int c = 1; c <= N + 2; c++) begin
            @(negedge in_clk);
            if (c == 1) begin
                sample_tick = 1'b0;
                din = DW'($urandom);
                chk("busy_start", busy, 1);
            end
            if (c == N + 1) begin
                chk("valid_early", dout_valid, 0);
                chk("busy_drain", busy, 1);
            end
        end
        chk("valid", dout_valid, 1);
        chk("dout", dout, exp);
        chk("busy_done", busy, 0);
        got_out = longint'(dout);
        for (int g = 0; g < gap; g++) begin
            @(negedge in_clk);
            if (g == 0) chk("valid_pulse", dout_valid, 0);
        end
    endtask

    initial begin
        int valids;
        longint exp;
        n_chk = 0;
        n_pass = 0;
        rst = 1'b0;
        sample_tick = 1'b0;
        din = '0;
        model_clear();

        // Step response: coefficients 0.5, din=1000, tick period 52.
        for (int i = 0; i < N; i++) rom[i] = 16'sd16384;
        apply_reset();
        for (int n = 1; n <= N + 6; n++) begin
            do_tick(16'sd1000, 52 - (N + 2));
            chk("step_closed", got_out, (n < N) ? 500 * n : 16000);
        end
        chk("step_no_ovr", overrun, 0);

        // Back-to-back ticks at minimum spacing.
        for (int n = 0; n < 4; n++) do_tick(DW'($urandom), 0);
        chk("b2b_no_ovr", overrun, 0);

        // Impulse response with coef[k]=100k.
        for (int i = 0; i < N; i++) rom[i] = CW'(100 * i);
        apply_reset();
        do_tick(16'sd32767, 1);
        chk("imp_0", got_out, 0);
        for (int n = 1; n <= 5; n++) begin
            do_tick(16'sd0, $urandom_range(0, 3));
            chk("imp_n", got_out, (longint'(3276700) * n) >>> 15);
        end

        // Saturation both directions.
        for (int i = 0; i < N; i++) rom[i] = 16'sd32767;
        for (int n = 0; n <= N; n++) do_tick(16'sd32767, 0);
        chk("sat_hi", got_out, 32767);
        for (int n = 0; n <= N; n++) do_tick(-16'sd32768, 0);
        chk("sat_lo", got_out, -32768);

        // Reset mid-sequence aborts with no output pulse.
        sample_tick = 1'b1;
        din = 16'sd1234;
        for (int c = 1; c <= 15; c++) begin
            @(negedge in_clk);
            if (c == 1) sample_tick = 1'b0;
        end
        rst = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_dout", dout, 0);
        chk("mid_valid", dout_valid, 0);
        valids = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge in_clk);
            if (c == 3) rst = 1'b1;
            valids += int'(dout_valid);
        end
        chk("mid_no_valid", valids, 0);
        model_clear();
        for (int i = 0; i < N; i++) rom[i] = CW'(100 * i);
        do_tick(16'sd32767, 0);
        chk("reimp_0", got_out, 0);
        for (int n = 1; n <= 5; n++) begin
            do_tick(16'sd0, 0);
            chk("reimp_n", got_out, (longint'(3276700) * n) >>> 15);
        end

        // Overrun: second tick 10 cycles after the first is dropped.
        for (int i = 0; i < N; i++) rom[i] = CW'($urandom);
        apply_reset();
        sample_tick = 1'b1;
        din = 16'sd2000;
        model_push(2000);
        exp = model_out();
        valids = 0;
        for (int c = 1; c <= N + 8; c++) begin
            @(negedge in_clk);
            if (c == 1) sample_tick = 1'b0;
            if (c == 10) begin
                chk("ovr_pre", overrun, 0);
                sample_tick = 1'b1;
                din = 16'sd12345;
            end
            if (c == 11) begin
                sample_tick = 1'b0;
                chk("ovr_set", overrun, 1);
            end
            if (c == N + 1) chk("ovr_busy", busy, 1);
            if (c == N + 2) chk("ovr_dout", dout, exp);
            valids += int'(dout_valid);
        end
        chk("ovr_valids", valids, 1);
        chk("ovr_sticky", overrun, 1);
        do_tick(DW'($urandom), 1);
        chk("ovr_sticky2", overrun, 1);

        // Wrap-around: ramp over several buffer wraps, random coefficients and gaps.
        for (int i = 0; i < N; i++) rom[i] = CW'($urandom);
        apply_reset();
        for (int n = 0; n < 3 * N + 5; n++) do_tick(DW'(n), $urandom_range(0, 4));

        // Fully random samples.
        for (int n = 0; n < 20; n++) do_tick(DW'($urandom), $urandom_range(0, 2));
        chk("rand_no_ovr", overrun, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Time-multiplexed FIR controller. It owns the circular sample history and one shared multiply-accumulate (MAC) datapath, and runs it N_TAPS times per input sample.
- Sequence is triggered by the one-cycle sample strobe from the clock divider.
- Sits between the divider/ADC sample source and the filter output register.
- Fetches coefficients from an external synchronous ROM.

Parameters:
N_TAPS, 32, number of filter taps (>=2, power of two not required)
DW, 16, signed sample/output width
CW, 16, signed coefficient width, Q1.(CW-1) format
AW, $clog2(N_TAPS), tap index/address width (derived, not overridden)

Ports:
in_clk  input  1  system clock
rst  input  1  asynchronous active-low reset
sample_tick  input  1  one-cycle strobe: new sample on din
din  input  DW  signed input sample, valid while sample_tick=1
coef_addr  output  AW  coefficient ROM address
coef_data  input  CW  signed coefficient, valid 1 cycle after coef_addr
dout  output  DW  signed filtered sample
dout_valid  output  1  one-cycle strobe, dout updated
busy  output  1  high while a sequence is in progress (state != IDLE)
overrun  output  1  sticky: sample_tick arrived while busy

Behaviour:
- Interface: reset rst, asynchronous, active-low; clock in_clk.
- Reset (async, rst=0) sets the following; any sequence in progress is aborted with no dout_valid.
  - State IDLE.
  - Sample buffer all zero, wr_ptr=0, k=0, acc=0.
  - dout=0, dout_valid=0, overrun=0, coef_addr=0.
- States: IDLE, MAC, DRAIN.
- IDLE, sample_tick=1 (cycle 0):
  - buf[wr_ptr]<=din, acc<=0, k<=0.
  - Next state MAC.
- MAC, cycles 1..N_TAPS, one tap per cycle:
  - coef_addr=k, driven combinationally from the k register.
  - smp_r <= buf[(wr_ptr-k) mod N_TAPS], so k=0 is the newest sample.
  - Each cycle, if the previous cycle was MAC: acc += smp_r*coef_data.
  - k increments. When k=N_TAPS-1, next state is DRAIN and k wraps to 0.
- DRAIN, cycle N_TAPS+1:
  - Accumulates the final product.
  - On the same edge: dout<=sat_DW(acc_final >>> (CW-1)), dout_valid<=1, wr_ptr<=(wr_ptr+1) mod N_TAPS.
  - Next state IDLE.
- Latency: tick at cycle 0 -> dout_valid high in cycle N_TAPS+2, for exactly 1 cycle.
- Minimum tick spacing is N_TAPS+2 cycles. A tick in the same cycle dout_valid is high is accepted.
- Arithmetic:
  - Products are DW+CW bits signed.
  - acc is DW+CW+AW bits signed and cannot overflow.
  - Shift is arithmetic (floor, no rounding).
  - Saturation clamps to [-2^(DW-1), 2^(DW-1)-1].
- wr_ptr wrap: N_TAPS-1 -> 0. Read index is computed modulo N_TAPS, which also covers non-power-of-two N_TAPS.
- sample_tick while busy: ignored (buffer, acc and k untouched), overrun<=1. overrun stays set until reset.
- dout holds its value between dout_valid pulses.

Decomposition:
- Shared package fir_pkg holds:
  - N_TAPS, DW, CW defaults.
  - State encoding constants ST_IDLE=2'd0, ST_MAC=2'd1, ST_DRAIN=2'd2.
  - Accumulator width function.
  - Saturation function.
- Natural sub-module: fir_mac, which is a registered signed multiply-accumulate with a synchronous clear and an enable. The sequencer drives clear on tick and enable in MAC/DRAIN.
- The clock_divider drives sample_tick at the top level; it is not instantiated inside this block.

Test Plan:
- Step response: all coefficients 16384 (0.5), din=1000 every tick, tick period 52 -> n-th output = 500*n for n=1..31, then constant 16000 from output 32 on. No overrun.
- Impulse response: coef[k]=100*k, din=32767 on the first tick, 0 afterwards -> output n = floor(3276700*n/32768). Expected outputs 0, 99, 199, ..., 499 at n=5. dout_valid occurs exactly N_TAPS+2=34 cycles after each tick.
- Saturation: all coefficients 32767, din=32767 held -> dout clamps to 32767. With din=-32768 held -> dout clamps to -32768.
- Overrun: ticks at cycles 0 and 10 -> only one dout_valid (cycle 34), overrun=1 from cycle 11. busy is high in cycles 1-33. Ticks spaced exactly 34 cycles -> all accepted, overrun stays 0.
- Reset mid-sequence: assert rst=0 at cycle 15 after a tick -> immediately busy=0, dout=0, dout_valid never pulses. After release, an impulse test reproduces the clean-start output sequence (buffer was zeroed).
- Wrap-around: run 3*N_TAPS+5 ticks with a ramp din=n -> every output matches the reference model computed from the last 32 samples across the wr_ptr wrap.
